sram_bist_sequencer: RTL and testbench

Upstream traffic generator for the SRAM controller in the memory lab datapath. On a start command it writes an address-derived pattern to every SRAM word, reads every word back, and compares each word against the expected value. It drives the controller's trigger, read/write select, address and write-data inputs, and consumes its registered read-data output. It reports pass/fail, a saturating error count and the first failing address.

---
 rtl/sram_bist_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_sram_bist_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sram_bist_sequencer.sv
// March-style write-all / read-all BIST traffic generator for the lab SRAM controller.
// Optional SRAM_BIST_INVERT_PASS_EN adds a second pass using the inverted pattern.
module sram_bist_sequencer #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int ACCESS_CYCLES = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [DATA_WIDTH-1:0] iSeed,
  input  logic [DATA_WIDTH-1:0] iSRAMDataRead,
  output logic                  oTrigger,
  output logic                  oReadSel,
  output logic [ADDR_WIDTH-1:0] oAddress,
  output logic [DATA_WIDTH-1:0] oDataOut,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oPass,
  output logic [15:0]           oErrorCount,
  output logic [ADDR_WIDTH-1:0] oFirstFailAddr
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RD_CHECK = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR  = '1;
  localparam logic [3:0]            WAIT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t                  state_q, state_d;
  logic                    trigger_q, trigger_d;
  logic                    read_sel_q, read_sel_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_ok_q, pass_ok_d;
  logic [15:0]             err_q, err_d;
  logic [ADDR_WIDTH-1:0]   first_fail_q, first_fail_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic [3:0]              wait_q, wait_d;
  logic                    invert_cur;
  logic [ADDR_WIDTH-1:0]   addr_inc;

`ifdef SRAM_BIST_INVERT_PASS_EN
  logic                    second_pass_q, second_pass_d;
  assign invert_cur = second_pass_q;
`else
  assign invert_cur = 1'b0;
`endif

  assign addr_inc = addr_q + 1'b1;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] seed,
                                                    input logic                  invert);
    logic [DATA_WIDTH-1:0] p;
    p = DATA_WIDTH'(a) ^ seed;
    return invert ? ~p : p;
  endfunction

  // NOTE: every _d gets its hold/default value first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    trigger_d    = 1'b0;
    read_sel_d   = read_sel_q;
    addr_d       = addr_q;
    data_d       = data_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_ok_d    = pass_ok_q;
    err_d        = err_q;
    first_fail_d = first_fail_q;
    seed_d       = seed_q;
    wait_d       = wait_q;
`ifdef SRAM_BIST_INVERT_PASS_EN
    second_pass_d = second_pass_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (iStart) begin
          seed_d       = iSeed;
          done_d       = 1'b0;
          pass_ok_d    = 1'b0;
          err_d        = '0;
          first_fail_d = '0;
          addr_d       = '0;
          busy_d       = 1'b1;
          trigger_d    = 1'b1;
          read_sel_d   = 1'b0;
          data_d       = pattern('0, iSeed, 1'b0);
          state_d      = WR_ISSUE;
`ifdef SRAM_BIST_INVERT_PASS_EN
          second_pass_d = 1'b0;
`endif
        end
      end

      WR_ISSUE: begin
        wait_d  = WAIT_LOAD;
        state_d = WR_WAIT;
      end

      WR_WAIT: begin
        if (wait_q == 4'd0) begin
          trigger_d = 1'b1;
          if (addr_q == MAX_ADDR) begin
            addr_d     = '0;
            read_sel_d = 1'b1;
            state_d    = RD_ISSUE;
          end else begin
            addr_d     = addr_inc;
            read_sel_d = 1'b0;
            data_d     = pattern(addr_inc, seed_q, invert_cur);
            state_d    = WR_ISSUE;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      RD_ISSUE: begin
        wait_d  = WAIT_LOAD;
        state_d = RD_WAIT;
      end

      RD_WAIT: begin
        if (wait_q == 4'd0) state_d = RD_CHECK;
        else                wait_d  = wait_q - 4'd1;
      end

      RD_CHECK: begin
        if (iSRAMDataRead != pattern(addr_q, seed_q, invert_cur)) begin
          // A count of zero can only mean no earlier mismatch, since it saturates rather than wraps.
          if (err_q == 16'd0)     first_fail_d = addr_q;
          if (err_q != 16'hFFFF) err_d        = err_q + 16'd1;
        end
        if (addr_q == MAX_ADDR) begin
`ifdef SRAM_BIST_INVERT_PASS_EN
          if (!second_pass_q) begin
            second_pass_d = 1'b1;
            addr_d        = '0;
            trigger_d     = 1'b1;
            read_sel_d    = 1'b0;
            data_d        = pattern('0, seed_q, 1'b1);
            state_d       = WR_ISSUE;
          end else begin
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_ok_d = (err_d == 16'd0);
            state_d   = DONE;
          end
`else
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_ok_d = (err_d == 16'd0);
          state_d   = DONE;
`endif
        end else begin
          addr_d     = addr_inc;
          trigger_d  = 1'b1;
          read_sel_d = 1'b1;
          state_d    = RD_ISSUE;
        end
      end

      default: begin
        state_d      = IDLE;
        read_sel_d   = 1'b0;
        addr_d       = '0;
        data_d       = '0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        pass_ok_d    = 1'b0;
        err_d        = '0;
        first_fail_d = '0;
        seed_d       = '0;
        wait_d       = '0;
`ifdef SRAM_BIST_INVERT_PASS_EN
        second_pass_d = 1'b0;
`endif
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      trigger_q    <= 1'b0;
      read_sel_q   <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_ok_q    <= 1'b0;
      err_q        <= '0;
      first_fail_q <= '0;
      seed_q       <= '0;
      wait_q       <= '0;
`ifdef SRAM_BIST_INVERT_PASS_EN
      second_pass_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      trigger_q    <= trigger_d;
      read_sel_q   <= read_sel_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_ok_q    <= pass_ok_d;
      err_q        <= err_d;
      first_fail_q <= first_fail_d;
      seed_q       <= seed_d;
      wait_q       <= wait_d;
`ifdef SRAM_BIST_INVERT_PASS_EN
      second_pass_q <= second_pass_d;
`endif
    end
  end

  assign oTrigger       = trigger_q;
  assign oReadSel       = read_sel_q;
  assign oAddress       = addr_q;
  assign oDataOut       = data_q;
  assign oBusy          = busy_q;
  assign oDone          = done_q;
  assign oPass          = pass_ok_q;
  assign oErrorCount    = err_q;
  assign oFirstFailAddr = first_fail_q;

endmodule

// File: tb/tb_sram_bist_sequencer.sv
// Directed bench for sram_bist_sequencer: behavioural SRAM with fault injection,
// trigger monitor and hand-computed expectations for each run.
module tb_sram_bist_sequencer;

`ifdef SRAM_BIST_INVERT_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int RUN_CYCLES = 2816 * NPASS;
  localparam int MAX_WAIT   = 12000;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iStart = 1'b0;
  logic [15:0] iSeed = '0;
  logic [15:0] iSRAMDataRead;
  logic        oTrigger, oReadSel, oBusy, oDone, oPass;
  logic [7:0]  oAddress, oFirstFailAddr;
  logic [15:0] oDataOut, oErrorCount;

  int vectors = 0;
  int miscompares = 0;

  sram_bist_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .ACCESS_CYCLES(4)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iSeed(iSeed),
    .iSRAMDataRead(iSRAMDataRead), .oTrigger(oTrigger), .oReadSel(oReadSel),
    .oAddress(oAddress), .oDataOut(oDataOut), .oBusy(oBusy), .oDone(oDone),
    .oPass(oPass), .oErrorCount(oErrorCount), .oFirstFailAddr(oFirstFailAddr)
  );

  always #5 Clock = ~Clock;

  // Behavioural controller: registered read data, faults applied on the read path.
  logic [15:0] mem [256];
  logic [15:0] rdata = '0;
  int          fault_mode = 0;
  int          wr_trigs = 0;
  int          rd_trigs = 0;
  int          back_to_back = 0;
  logic        prev_trig = 1'b0;

  assign iSRAMDataRead = rdata;

  function automatic logic [15:0] corrupt(input logic [15:0] d, input logic [7:0] a, input int mode);
    case (mode)
      1:       return d & ~16'h0008;
      2:       return (a == 8'hFF) ? (d ^ 16'h0001) : d;
      3:       return d | 16'h0001;
      default: return d;
    endcase
  endfunction

  always @(posedge Clock) begin
    if (oTrigger && !oReadSel) begin
      mem[oAddress] <= oDataOut;
      wr_trigs <= wr_trigs + 1;
    end
    if (oTrigger && oReadSel) begin
      rdata <= corrupt(mem[oAddress], oAddress, fault_mode);
      rd_trigs <= rd_trigs + 1;
    end
    if (oTrigger && prev_trig) back_to_back <= back_to_back + 1;
    prev_trig <= oTrigger;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Accept a start, check the first WR_ISSUE cycle, then run until done (bounded).
  task automatic run(input string name, input logic [15:0] seed, input int fault, input int hold_start,
                     output int cycles, output int wr, output int rd, output logic [15:0] data_12);
    int   wr0, rd0;
    logic probed;
    probed  = 1'b0;
    data_12 = 'x;
    @(negedge Clock);
    fault_mode = fault;
    wr0 = wr_trigs;
    rd0 = rd_trigs;
    iSeed  = seed;
    iStart = 1'b1;
    @(posedge Clock); #1;
    check({name, " busy@start"}, oBusy, 1'b1);
    check({name, " trig@start"}, oTrigger, 1'b1);
    check({name, " rdsel@start"}, oReadSel, 1'b0);
    check({name, " addr@start"}, oAddress, 8'h00);
    check({name, " data@addr0"}, oDataOut, seed);
    check({name, " done cleared"}, oDone, 1'b0);
    check({name, " err cleared"}, oErrorCount, 16'h0000);
    check({name, " ffa cleared"}, oFirstFailAddr, 8'h00);
    cycles = 0;
    while (!oDone && cycles < MAX_WAIT) begin
      if (cycles >= hold_start) iStart = 1'b0;
      if (!probed && oTrigger && !oReadSel && oAddress == 8'h12) begin
        data_12 = oDataOut;
        probed  = 1'b1;
      end
      @(posedge Clock); #1;
      cycles++;
    end
    iStart = 1'b0;
    check({name, " finished in budget"}, oDone, 1'b1);
    wr = wr_trigs - wr0;
    rd = rd_trigs - rd0;
  endtask

  initial begin
    int          cycles, wr, rd;
    logic [15:0] d12;

    // Reset values.
    #2;
    check("reset trig", oTrigger, 1'b0);
    check("reset busy", oBusy, 1'b0);
    check("reset done", oDone, 1'b0);
    check("reset data", oDataOut, 16'h0000);
    check("reset err", oErrorCount, 16'h0000);
    @(negedge Clock); Reset = 1'b0;

    // 1. Reset asserted in WR_WAIT clears everything in the same cycle.
    @(negedge Clock); iSeed = 16'h1234; iStart = 1'b1;
    @(posedge Clock); #1; iStart = 1'b0;
    repeat (2) begin @(posedge Clock); #1; end
    check("mid-run busy", oBusy, 1'b1);
    check("mid-run data held", oDataOut, 16'h1234);
    #2 Reset = 1'b1;
    #1;
    check("async rst busy", oBusy, 1'b0);
    check("async rst data", oDataOut, 16'h0000);
    check("async rst trig", oTrigger, 1'b0);
    check("async rst addr", oAddress, 8'h00);
    @(negedge Clock); Reset = 1'b0;
    repeat (3) begin @(posedge Clock); #1; end
    check("idle after rst busy", oBusy, 1'b0);
    check("idle after rst trig", oTrigger, 1'b0);
    check("idle after rst done", oDone, 1'b0);

    // 2. Ideal SRAM, seed A5A5.
    run("ideal", 16'hA5A5, 0, 0, cycles, wr, rd, d12);
    check("ideal cycles", cycles, RUN_CYCLES);
    check("ideal writes", wr, 256 * NPASS);
    check("ideal reads", rd, 256 * NPASS);
    check("ideal data@12", d12, 16'hA5B7);
    check("ideal pass", oPass, 1'b1);
    check("ideal err", oErrorCount, 16'h0000);
    check("ideal busy", oBusy, 1'b0);

    // 3. Bit 3 stuck at 0, seed 0; results must hold in DONE.
    run("stuck3", 16'h0000, 1, 0, cycles, wr, rd, d12);
    check("stuck3 err", oErrorCount, 128 * NPASS);
    check("stuck3 ffa", oFirstFailAddr, 8'h08);
    check("stuck3 pass", oPass, 1'b0);
    repeat (10) @(posedge Clock); #1;
    check("done hold flag", oDone, 1'b1);
    check("done hold err", oErrorCount, 128 * NPASS);
    check("done hold trig", oTrigger, 1'b0);

    // 4. Only the last address is corrupted.
    run("last addr", 16'h3C3C, 2, 0, cycles, wr, rd, d12);
    check("last addr err", oErrorCount, NPASS);
    check("last addr ffa", oFirstFailAddr, 8'hFF);
    check("last addr pass", oPass, 1'b0);

    // 5. iStart held high through the first 1000 cycles: no restart; starting from DONE clears results.
    run("start spam", 16'h0F0F, 0, 1000, cycles, wr, rd, d12);
    check("spam cycles", cycles, RUN_CYCLES);
    check("spam writes", wr, 256 * NPASS);
    check("spam reads", rd, 256 * NPASS);
    check("spam pass", oPass, 1'b1);
    check("spam data@12", d12, 16'h0F1D);

`ifdef SRAM_BIST_INVERT_PASS_EN
    // 6. Bit 0 stuck at 1: even addresses fail in pass 1, odd in pass 2.
    run("invert", 16'h0000, 3, 0, cycles, wr, rd, d12);
    check("invert cycles", cycles, 5632);
    check("invert err", oErrorCount, 256);
    check("invert ffa", oFirstFailAddr, 8'h00);
    check("invert pass", oPass, 1'b0);
`endif

    check("no back-to-back triggers", back_to_back, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
